// File: rtl/arm_pkg.sv
// Shared widths, writeback request type and destination decode for the
// register-file write-port arbiter.
package arm_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [NREGS-1:0] dest_onehot(input logic [ADDR_W-1:0] dest);
    logic [NREGS-1:0] oh;
    oh       = {NREGS{1'b0}};
    oh[dest] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry shift FIFO for long-latency results; slot 0 is always the head.
// Entry valids and destinations are exported for hazard and pending-mask decode.
module wb_fifo2
  import arm_pkg::*;
(
  input  logic              nclk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  wb_req_t           din,
  output wb_req_t           head,
  output logic [1:0]        count,
  output logic [1:0]        valid,
  output logic [ADDR_W-1:0] dest0,
  output logic [ADDR_W-1:0] dest1
);

  wb_req_t    slot0_r;
  wb_req_t    slot1_r;
  logic [1:0] count_r;
  logic       push_ok_s;
  logic       pop_ok_s;

  assign push_ok_s = push && (count_r != 2'd2);
  assign pop_ok_s  = pop && (count_r != 2'd0);

  // Storage and occupancy update; a simultaneous push/pop at count 1 replaces the head
  always_ff @(posedge nclk or negedge rst) begin
    if (!rst) begin
      slot0_r <= '0;
      slot1_r <= '0;
      count_r <= 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            slot0_r <= din;
          end else begin
            slot1_r <= din;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          slot0_r <= slot1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            slot0_r <= din;
          end else begin
            slot0_r <= slot1_r;
            slot1_r <= din;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign head  = slot0_r;
  assign count = count_r;
  assign valid = {count_r == 2'd2, count_r != 2'd0};
  assign dest0 = slot0_r.dest;
  assign dest1 = slot1_r.dest;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline writeback and
// buffered long-latency results, stalling the pipeline for ordering or starvation.
module wb_port_arbiter #(
  parameter int DATA_W       = arm_pkg::DATA_W,
  parameter int ADDR_W       = arm_pkg::ADDR_W,
  parameter int NREGS        = arm_pkg::NREGS,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              nclk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_dest,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  output logic              stall_pipe,
  output logic [NREGS-1:0]  pending_mask,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arm_pkg::wb_req_t  lu_req_s;
  arm_pkg::wb_req_t  head_s;
  arm_pkg::wb_req_t  grant_req_s;
  logic [1:0]        count_s;
  logic [1:0]        valid_s;
  logic [ADDR_W-1:0] dest0_s;
  logic [ADDR_W-1:0] dest1_s;
  logic              push_s;
  logic              pop_s;
  logic              grant_s;
  logic              nonempty_s;
  logic              dest_hit_s;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic [CNT_W-1:0]  starve_cnt_next_s;
  logic              starve_flag_r;
  logic              starve_flag_next_s;

  assign lu_req_s   = '{dest: lu_dest, data: lu_data};
  assign lu_ready   = (count_s != 2'd2);
  assign push_s     = lu_valid && lu_ready;
  assign nonempty_s = (count_s != 2'd0);
  // Only stored entries are compared; a result arriving this cycle cannot collide yet
  assign dest_hit_s = wb_we && ((valid_s[0] && (dest0_s == wb_dest)) ||
                               (valid_s[1] && (dest1_s == wb_dest)));
  assign stall_pipe = starve_flag_r || dest_hit_s;

  wb_fifo2 u_fifo (
    .nclk  (nclk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (lu_req_s),
    .head  (head_s),
    .count (count_s),
    .valid (valid_s),
    .dest0 (dest0_s),
    .dest1 (dest1_s)
  );

  // Port grant: a stall hands the port to the FIFO head, else the pipeline wins
  always_comb begin
    pop_s       = 1'b0;
    grant_s     = 1'b0;
    grant_req_s = '{dest: wb_dest, data: wb_data};
    if (stall_pipe && nonempty_s) begin
      pop_s       = 1'b1;
      grant_s     = 1'b1;
      grant_req_s = head_s;
    end else if (wb_we && !stall_pipe) begin
      grant_s = 1'b1;
    end else if (nonempty_s) begin
      pop_s       = 1'b1;
      grant_s     = 1'b1;
      grant_req_s = head_s;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Starvation tracking; the flag lasts one cycle because it forces the head out
  always_comb begin
    starve_cnt_next_s  = {CNT_W{1'b0}};
    starve_flag_next_s = 1'b0;
    if (nonempty_s && !pop_s) begin
      starve_cnt_next_s  = starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      starve_flag_next_s = (starve_cnt_next_s == CNT_W'(STARVE_LIMIT));
    end else begin
      starve_cnt_next_s  = {CNT_W{1'b0}};
      starve_flag_next_s = 1'b0;
    end
  end

  // Starvation state register
  always_ff @(posedge nclk or negedge rst) begin
    if (!rst) begin
      starve_cnt_r  <= {CNT_W{1'b0}};
      starve_flag_r <= 1'b0;
    end else begin
      starve_cnt_r  <= starve_cnt_next_s;
      starve_flag_r <= starve_flag_next_s;
    end
  end

  // Register-file write port; address and data hold when nothing is granted
  always_ff @(posedge nclk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_addr  <= {ADDR_W{1'b0}};
      rf_wdata <= {DATA_W{1'b0}};
    end else begin
      rf_we <= grant_s;
      if (grant_s) begin
        rf_addr  <= grant_req_s.dest;
        rf_wdata <= grant_req_s.data;
      end
    end
  end

  // Pending destinations, decoded from stored entries only
  always_comb begin
    pending_mask = {NREGS{1'b0}};
    if (valid_s[0]) begin
      pending_mask = pending_mask | arm_pkg::dest_onehot(dest0_s);
    end else begin
      pending_mask = pending_mask;
    end
    if (valid_s[1]) begin
      pending_mask = pending_mask | arm_pkg::dest_onehot(dest1_s);
    end else begin
      pending_mask = pending_mask;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter: reset, LU path, starvation,
// ordering hazard, simultaneous push/pop, same-dest chain and mid-operation reset.
module tb_wb_port_arbiter;

  logic        nclk;
  logic        rst;
  logic        wb_we;
  logic [3:0]  wb_dest;
  logic [7:0]  wb_data;
  logic        lu_valid;
  logic [3:0]  lu_dest;
  logic [7:0]  lu_data;
  logic        lu_ready;
  logic        stall_pipe;
  logic [15:0] pending_mask;
  logic        rf_we;
  logic [3:0]  rf_addr;
  logic [7:0]  rf_wdata;
  logic [7:0]  rf_model [16];

  int checks   = 0;
  int failures = 0;

  wb_port_arbiter dut (
    .nclk         (nclk),
    .rst          (rst),
    .wb_we        (wb_we),
    .wb_dest      (wb_dest),
    .wb_data      (wb_data),
    .lu_valid     (lu_valid),
    .lu_dest      (lu_dest),
    .lu_data      (lu_data),
    .lu_ready     (lu_ready),
    .stall_pipe   (stall_pipe),
    .pending_mask (pending_mask),
    .rf_we        (rf_we),
    .rf_addr      (rf_addr),
    .rf_wdata     (rf_wdata)
  );

  initial nclk = 1'b0;
  always #5 nclk = ~nclk;

  // Register file fed by the write port, committing at the edge that samples rf_we
  always @(posedge nclk) begin
    if (rst && rf_we) rf_model[rf_addr] <= rf_wdata;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge nclk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_model[i] = 8'h00;
    rst = 1'b0; wb_we = 1'b1; wb_dest = 4'd3; wb_data = 8'h5A;
    lu_valid = 1'b1; lu_dest = 4'd7; lu_data = 8'h11;
    tick; tick;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
    chk("rst_lu_ready", 32'(lu_ready), 32'd1);
    chk("rst_stall", 32'(stall_pipe), 32'd0);
    chk("rst_mask", 32'(pending_mask), 32'd0);

    rst = 1'b1; lu_valid = 1'b0;
    tick;
    chk("wb_first_we", 32'(rf_we), 32'd1);
    chk("wb_first_addr", 32'(rf_addr), 32'd3);
    chk("wb_first_data", 32'(rf_wdata), 32'h5A);
    wb_we = 1'b0;
    tick;
    chk("idle_we", 32'(rf_we), 32'd0);
    chk("idle_addr_hold", 32'(rf_addr), 32'd3);
    chk("idle_data_hold", 32'(rf_wdata), 32'h5A);

    // LU result alone
    lu_valid = 1'b1; lu_dest = 4'd7; lu_data = 8'h11;
    tick;
    lu_valid = 1'b0; #1;
    chk("lu_mask", 32'(pending_mask), 32'h0080);
    chk("lu_no_write_yet", 32'(rf_we), 32'd0);
    tick;
    chk("lu_we", 32'(rf_we), 32'd1);
    chk("lu_addr", 32'(rf_addr), 32'd7);
    chk("lu_data", 32'(rf_wdata), 32'h11);
    chk("lu_mask_clear", 32'(pending_mask), 32'd0);

    // Backpressure and starvation with continuous pipeline writes
    wb_we = 1'b1; wb_dest = 4'd8; wb_data = 8'hA0;
    lu_valid = 1'b1; lu_dest = 4'd1; lu_data = 8'h41;
    tick;
    chk("bp_mask1", 32'(pending_mask), 32'h0002);
    chk("bp_ready1", 32'(lu_ready), 32'd1);
    chk("bp_wb_addr", 32'(rf_addr), 32'd8);
    lu_dest = 4'd2; lu_data = 8'h42;
    tick;
    lu_valid = 1'b0; #1;
    chk("bp_ready_full", 32'(lu_ready), 32'd0);
    chk("bp_mask2", 32'(pending_mask), 32'h0006);
    chk("bp_stall_e2", 32'(stall_pipe), 32'd0);
    tick;
    chk("bp_stall_e3", 32'(stall_pipe), 32'd0);
    tick;
    chk("bp_stall_e4", 32'(stall_pipe), 32'd0);
    tick;
    chk("bp_stall_pulse1", 32'(stall_pipe), 32'd1);
    chk("bp_wb_still_written", 32'(rf_addr), 32'd8);
    tick;
    chk("bp_pop1_addr", 32'(rf_addr), 32'd1);
    chk("bp_pop1_data", 32'(rf_wdata), 32'h41);
    chk("bp_pulse1_end", 32'(stall_pipe), 32'd0);
    chk("bp_mask_after1", 32'(pending_mask), 32'h0004);
    chk("bp_ready_again", 32'(lu_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_second_wait", 32'(stall_pipe), 32'd0);
    end
    tick;
    chk("bp_stall_pulse2", 32'(stall_pipe), 32'd1);
    tick;
    chk("bp_pop2_addr", 32'(rf_addr), 32'd2);
    chk("bp_pop2_data", 32'(rf_wdata), 32'h42);
    chk("bp_mask_empty", 32'(pending_mask), 32'd0);

    // Ordering hazard: buffered write to r5 must land before the pipeline's
    lu_valid = 1'b1; lu_dest = 4'd5; lu_data = 8'h22;
    wb_dest = 4'd9; wb_data = 8'h99;
    tick;
    chk("hz_wb9", 32'(rf_addr), 32'd9);
    lu_valid = 1'b0; wb_dest = 4'd5; wb_data = 8'h33; #1;
    chk("hz_stall", 32'(stall_pipe), 32'd1);
    chk("hz_mask", 32'(pending_mask), 32'h0020);
    tick;
    chk("hz_lu_addr", 32'(rf_addr), 32'd5);
    chk("hz_lu_data", 32'(rf_wdata), 32'h22);
    chk("hz_stall_off", 32'(stall_pipe), 32'd0);
    tick;
    chk("hz_wb_addr", 32'(rf_addr), 32'd5);
    chk("hz_wb_data", 32'(rf_wdata), 32'h33);
    wb_we = 1'b0;
    tick;
    chk("hz_reg5_final", 32'(rf_model[5]), 32'h33);

    // Simultaneous pop and push at count 1
    lu_valid = 1'b1; lu_dest = 4'd4; lu_data = 8'h44;
    tick;
    lu_dest = 4'd6; lu_data = 8'h66; #1;
    chk("sim_ready", 32'(lu_ready), 32'd1);
    chk("sim_mask_before", 32'(pending_mask), 32'h0010);
    tick;
    chk("sim_pop_addr", 32'(rf_addr), 32'd4);
    chk("sim_pop_data", 32'(rf_wdata), 32'h44);
    chk("sim_mask_after", 32'(pending_mask), 32'h0040);
    chk("sim_ready_after", 32'(lu_ready), 32'd1);
    lu_valid = 1'b0;
    tick;
    chk("sim_second_addr", 32'(rf_addr), 32'd6);
    chk("sim_second_data", 32'(rf_wdata), 32'h66);
    chk("sim_mask_empty", 32'(pending_mask), 32'd0);

    // Two buffered writes to the same register, then a pipeline write to it
    wb_we = 1'b1; wb_dest = 4'd8; wb_data = 8'hA1;
    lu_valid = 1'b1; lu_dest = 4'd12; lu_data = 8'hC1;
    tick;
    lu_data = 8'hC2;
    tick;
    lu_valid = 1'b0; wb_dest = 4'd12; wb_data = 8'hC3; #1;
    chk("chain_mask_single", 32'(pending_mask), 32'h1000);
    chk("chain_stall1", 32'(stall_pipe), 32'd1);
    tick;
    chk("chain_first", 32'(rf_wdata), 32'hC1);
    chk("chain_stall2", 32'(stall_pipe), 32'd1);
    tick;
    chk("chain_second", 32'(rf_wdata), 32'hC2);
    chk("chain_stall_off", 32'(stall_pipe), 32'd0);
    tick;
    chk("chain_wb_addr", 32'(rf_addr), 32'd12);
    chk("chain_wb_data", 32'(rf_wdata), 32'hC3);

    // Mid-operation reset with a full FIFO and a partly advanced starve counter
    wb_dest = 4'd8; wb_data = 8'hA2;
    lu_valid = 1'b1; lu_dest = 4'd10; lu_data = 8'hD0;
    tick;
    lu_dest = 4'd11; lu_data = 8'hD1;
    tick;
    lu_valid = 1'b0;
    tick; tick;
    chk("mid_mask_full", 32'(pending_mask), 32'h0C00);
    chk("mid_no_stall_yet", 32'(stall_pipe), 32'd0);
    #2; rst = 1'b0; #1;
    chk("mid_rst_mask", 32'(pending_mask), 32'd0);
    chk("mid_rst_ready", 32'(lu_ready), 32'd1);
    chk("mid_rst_stall", 32'(stall_pipe), 32'd0);
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    wb_we = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    chk("mid_post_we1", 32'(rf_we), 32'd0);
    tick;
    chk("mid_post_we2", 32'(rf_we), 32'd0);
    chk("mid_post_mask", 32'(pending_mask), 32'd0);
    chk("mid_post_stall", 32'(stall_pipe), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters: the pipeline writeback (MEM/WB stage fields) and the long-latency unit (LU) result stream.
- LU results are buffered in a 2-entry FIFO and exposed as a pending-register mask for the hazard unit.
- Pipeline writeback has priority; the block stalls the pipeline for ordering or anti-starvation.
- Sits between the MEM/WB pipeline register, the LU and the register file.

Parameters:
DATA_W, 8, register data width
ADDR_W, 4, register address width
NREGS, 16, number of architectural registers (2**ADDR_W)
STARVE_LIMIT, 4, consecutive cycles an LU head may be denied before a forced stall

Ports:
nclk  in  1  clock, rising-edge active
rst  in  1  reset, asynchronous, active-low (0 = reset)
wb_we  in  1  pipeline writeback request (MEM/WB reg_write)
wb_dest  in  ADDR_W  pipeline writeback destination
wb_data  in  DATA_W  pipeline writeback data
lu_valid  in  1  LU result valid
lu_dest  in  ADDR_W  LU result destination
lu_data  in  DATA_W  LU result data
lu_ready  out  1  FIFO can accept an LU result
stall_pipe  out  1  freeze IF..MEM/WB this cycle; pipeline writeback not taken
pending_mask  out  NREGS  one-hot OR of destinations held in FIFO
rf_we  out  1  register-file write enable
rf_addr  out  ADDR_W  register-file write address
rf_wdata  out  DATA_W  register-file write data

Behaviour:
- Reset (rst=0, async): FIFO emptied, starve counter=0, starve flag=0. rf_we=0, rf_addr=0, rf_wdata=0, lu_ready=1, stall_pipe=0, pending_mask=0. Reset mid-operation discards all buffered LU results.
- FIFO: depth 2. lu_ready = (count<2), decoded from registered count only, with no combinational path from the pop decision. Push when lu_valid&&lu_ready. Push and pop in the same cycle are legal at count 1; at count 0 a push is not eligible for grant in the same cycle. Order is strictly FIFO.
- dest_hit = wb_we && (wb_dest matches any valid FIFO entry), combinational on stored entries only. A same-cycle push is not checked.
- stall_pipe = starve_flag || dest_hit (combinational).
- Grant each cycle, in priority order:
  - stall_pipe=1 and FIFO non-empty: grant FIFO head (pop). The pipeline holds, so the MEM/WB request re-presents next cycle.
  - else wb_we=1: grant the pipeline.
  - else FIFO non-empty: grant FIFO head.
  - else: no grant.
- Output latency is 1: the granted dest/data are registered to rf_addr/rf_wdata with rf_we=1 at the next posedge. With no grant, rf_we=0 and rf_addr/rf_wdata hold.
- An LU result accepted at edge N is earliest written at edge N+2.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the head is not granted.
  - Clears on head grant or when the FIFO is empty.
  - On reaching STARVE_LIMIT, starve_flag sets at that edge, giving exactly one stall cycle.
  - starve_flag clears at the next edge and the counter clears.
- pending_mask: bit i=1 iff a valid FIFO entry has dest i; two entries with the same dest give a single bit. Derived from the registered FIFO state.
- Same-dest entries in the FIFO both write, in order; the last one wins.
- dest_hit with a 2-deep chain: the stall persists until no entry matches, i.e. one or two stall cycles.
- The block never drops a request: each pipeline request with wb_we=1 and stall_pipe=0 is written exactly once.

Decomposition:
- Shared package arm_pkg: DATA_W, ADDR_W, NREGS constants; wb_req_t struct {dest, data}.
- One sub-module: wb_fifo2 (2-entry FIFO: push/pop/count/entry valids and dests exported for dest_hit and pending_mask).
- Grant logic, starve counter and output register stay in the top module.

Test Plan:
- Reset: hold rst=0 with stimulus active -> all outputs 0, lu_ready=1. Release, then wb_we=1, dest=3, data=0x5A -> rf_we=1, rf_addr=3, rf_wdata=0x5A one edge later.
- LU alone: lu_valid=1 dest=7 data=0x11 at edge N, wb_we=0 -> pending_mask=0x0080 after N, rf write 7/0x11 at N+2, mask back to 0.
- Backpressure: wb_we=1 every cycle, push LU dest 1 and dest 2 -> lu_ready=0 after the second push. After 4 denied cycles, one stall_pipe pulse pops dest 1; the next starve period pops dest 2.
- Ordering hazard: FIFO holds dest 5=0x22; wb_we=1 dest=5 data=0x33 -> stall_pipe=1 one cycle, LU write 5/0x22 first, then 5/0x33 next cycle; final reg5=0x33.
- Simultaneous: count=1 (dest 4), lu_valid with dest 6, wb_we=0 -> head dest 4 popped and dest 6 pushed the same edge; count stays 1, pending_mask=0x0040.
- Mid-op reset: FIFO full, starve counter at 3, assert rst -> FIFO empty, stall_pipe=0, no spurious rf_we after release.
